// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
// Contents:
//   FS_CLR/FS_LOAD/FS_DEC/FS_INC : FunSel operation encodings
//   addr_w()                     : width of a register address for a given depth
package regfile_pkg;

    localparam logic [1:0] FS_CLR  = 2'b00;
    localparam logic [1:0] FS_LOAD = 2'b01;
    localparam logic [1:0] FS_DEC  = 2'b10;
    localparam logic [1:0] FS_INC  = 2'b11;

    // Address width for a register file of 'depth' entries (at least 1 bit).
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_cell.sv
// One register of the register file with its sticky Wrap bit.
// Ports:
//   CLK     : clock, updates on rising edge
//   RST     : asynchronous active-high reset (Q=0, Wrap=0)
//   E       : enable; when low the register holds
//   FunSel  : operation (clear, load, decrement, increment)
//   I       : load data
//   FlagClr : synchronous clear of Wrap (a wrap event on the same edge wins)
//   Q       : stored value
//   Wrap    : sticky overflow/underflow flag
module regfile_cell
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             E,
    input  logic [1:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    input  logic             FlagClr,
    output logic [WIDTH-1:0] Q,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_evt;

    always_comb begin
        w_next     = r_q;
        w_wrap_evt = 1'b0;
        if (E) begin
            case (FunSel)
                FS_CLR:  w_next = '0;
                FS_LOAD: w_next = I;
                FS_DEC: begin
                    if (r_q == '0) begin
                        w_wrap_evt = 1'b1;
                        w_next     = (SATURATE != 0) ? '0 : ALL_ONES;
                    end else begin
                        w_next = r_q - ONE;
                    end
                end
                default: begin
                    if (r_q == ALL_ONES) begin
                        w_wrap_evt = 1'b1;
                        w_next     = (SATURATE != 0) ? ALL_ONES : '0;
                    end else begin
                        w_next = r_q + ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q <= w_next;
            // Setting has priority over the clear.
            if (w_wrap_evt) begin
                r_wrap <= 1'b1;
            end else if (FlagClr) begin
                r_wrap <= 1'b0;
            end
        end
    end

    assign Q    = r_q;
    assign Wrap = r_wrap;

endmodule

// File: rtl/regfile_param.sv
// Parametrised WIDTH x DEPTH register file with two combinational read ports.
// Ports:
//   CLK, RST         : clock and asynchronous active-high reset
//   FunSel           : shared operation for all enabled registers
//   RegSel           : per-register enable mask
//   I                : load data
//   OutASel/OutBSel  : read addresses (addresses >= DEPTH read as 0)
//   FlagClr          : synchronous clear of all Wrap flags
//   OutA/OutB        : read data (optionally bypassed from I on a load)
//   ZeroA            : OutA == 0
//   Wrap             : sticky per-register overflow/underflow flags
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int SATURATE = 0,
    parameter int BYPASS   = 0,
    localparam int AW      = addr_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       FunSel,
    input  logic [DEPTH-1:0] RegSel,
    input  logic [WIDTH-1:0] I,
    input  logic [AW-1:0]    OutASel,
    input  logic [AW-1:0]    OutBSel,
    input  logic             FlagClr,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic             ZeroA,
    output logic [DEPTH-1:0] Wrap
);

    logic [WIDTH-1:0] w_q [DEPTH];
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_load_byp;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
        regfile_cell #(
            .WIDTH   (WIDTH),
            .SATURATE(SATURATE)
        ) u_cell (
            .CLK    (CLK),
            .RST    (RST),
            .E      (RegSel[gi]),
            .FunSel (FunSel),
            .I      (I),
            .FlagClr(FlagClr),
            .Q      (w_q[gi]),
            .Wrap   (Wrap[gi])
        );
    end

    // Bypass is suppressed while in reset so the ports read 0 throughout reset.
    assign w_load_byp = (BYPASS != 0) && (FunSel == FS_LOAD) && !RST;

    // Matching against each valid index leaves out-of-range addresses at 0.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (OutASel == k[AW-1:0]) begin
                w_a = (w_load_byp && RegSel[k]) ? I : w_q[k];
            end
            if (OutBSel == k[AW-1:0]) begin
                w_b = (w_load_byp && RegSel[k]) ? I : w_q[k];
            end
        end
    end

    assign OutA  = w_a;
    assign OutB  = w_b;
    assign ZeroA = (w_a == '0);

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three 8x4 instances (wrap, saturate, bypass) sharing
// stimulus, plus a 4-bit x 6 instance, each tracked by a behavioural model.
module tb_regfile_param;

    localparam logic [1:0] CLR = 2'b00, LD = 2'b01, DEC = 2'b10, INC = 2'b11;

    logic       CLK;
    logic       RST;
    logic [1:0] FunSel;
    logic [3:0] RegSel;
    logic [7:0] I;
    logic [1:0] OutASel, OutBSel;
    logic       FlagClr;

    logic [2:0][7:0] oa, ob;
    logic [2:0]      za;
    logic [2:0][3:0] wr;

    logic [1:0] f6;
    logic [5:0] rs6;
    logic [3:0] i6;
    logic [2:0] a6, b6;
    logic       fc6;
    logic [3:0] oa6, ob6;
    logic       za6;
    logic [5:0] w6;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    regfile_param #(.WIDTH(8), .DEPTH(4), .SATURATE(0), .BYPASS(0)) u_wrap (
        .CLK(CLK), .RST(RST), .FunSel(FunSel), .RegSel(RegSel), .I(I),
        .OutASel(OutASel), .OutBSel(OutBSel), .FlagClr(FlagClr),
        .OutA(oa[0]), .OutB(ob[0]), .ZeroA(za[0]), .Wrap(wr[0]));

    regfile_param #(.WIDTH(8), .DEPTH(4), .SATURATE(1), .BYPASS(0)) u_sat (
        .CLK(CLK), .RST(RST), .FunSel(FunSel), .RegSel(RegSel), .I(I),
        .OutASel(OutASel), .OutBSel(OutBSel), .FlagClr(FlagClr),
        .OutA(oa[1]), .OutB(ob[1]), .ZeroA(za[1]), .Wrap(wr[1]));

    regfile_param #(.WIDTH(8), .DEPTH(4), .SATURATE(0), .BYPASS(1)) u_byp (
        .CLK(CLK), .RST(RST), .FunSel(FunSel), .RegSel(RegSel), .I(I),
        .OutASel(OutASel), .OutBSel(OutBSel), .FlagClr(FlagClr),
        .OutA(oa[2]), .OutB(ob[2]), .ZeroA(za[2]), .Wrap(wr[2]));

    regfile_param #(.WIDTH(4), .DEPTH(6), .SATURATE(0), .BYPASS(0)) u_p6 (
        .CLK(CLK), .RST(RST), .FunSel(f6), .RegSel(rs6), .I(i6),
        .OutASel(a6), .OutBSel(b6), .FlagClr(fc6),
        .OutA(oa6), .OutB(ob6), .ZeroA(za6), .Wrap(w6));

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- behavioural model ----------------
    logic [7:0] m_r [3][4];
    logic [3:0] m_w [3];
    logic [3:0] m6_r [6];
    logic [5:0] m6_w;

    function automatic int nxt(input int v, input int fs, input int din,
                               input int maxv, input bit sat, output bit ev);
        ev = 0;
        case (fs)
            0: return 0;
            1: return din;
            2: if (v == 0) begin ev = 1; return sat ? 0 : maxv; end
               else return v - 1;
            default: if (v == maxv) begin ev = 1; return sat ? maxv : 0; end
                     else return v + 1;
        endcase
    endfunction

    always @(posedge CLK or posedge RST) begin
        int nv;
        bit ev;
        logic [3:0] nw;
        logic [5:0] nw6;
        if (RST) begin
            for (int c = 0; c < 3; c++) begin
                for (int k = 0; k < 4; k++) m_r[c][k] <= 8'h00;
                m_w[c] <= 4'h0;
            end
            for (int k = 0; k < 6; k++) m6_r[k] <= 4'h0;
            m6_w <= 6'h00;
        end else begin
            for (int c = 0; c < 3; c++) begin
                nw = FlagClr ? 4'h0 : m_w[c];
                for (int k = 0; k < 4; k++) begin
                    if (RegSel[k]) begin
                        nv = nxt(int'(m_r[c][k]), int'(FunSel), int'(I), 255, (c == 1), ev);
                        m_r[c][k] <= nv[7:0];
                        if (ev) nw[k] = 1'b1;
                    end
                end
                m_w[c] <= nw;
            end
            nw6 = fc6 ? 6'h00 : m6_w;
            for (int k = 0; k < 6; k++) begin
                if (rs6[k]) begin
                    nv = nxt(int'(m6_r[k]), int'(f6), int'(i6), 15, 1'b0, ev);
                    m6_r[k] <= nv[3:0];
                    if (ev) nw6[k] = 1'b1;
                end
            end
            m6_w <= nw6;
        end
    end

    function automatic logic [7:0] exp_rd(input int c, input int addr);
        if (RST) return 8'h00;
        if (c == 2 && FunSel == LD && RegSel[addr]) return I;
        return m_r[c][addr];
    endfunction

    function automatic logic [3:0] exp_rd6(input int addr);
        if (RST || addr >= 6) return 4'h0;
        return m6_r[addr];
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        logic [7:0] ea;
        logic [3:0] e6;
        if (cmp_en) begin
            for (int c = 0; c < 3; c++) begin
                ea = exp_rd(c, int'(OutASel));
                chk($sformatf("cmp_outA[%0d]", c), {8'h0, oa[c]}, {8'h0, ea});
                chk($sformatf("cmp_zeroA[%0d]", c), {15'h0, za[c]}, {15'h0, ea == 8'h00});
                chk($sformatf("cmp_outB[%0d]", c), {8'h0, ob[c]}, {8'h0, exp_rd(c, int'(OutBSel))});
                chk($sformatf("cmp_wrap[%0d]", c), {12'h0, wr[c]}, {12'h0, RST ? 4'h0 : m_w[c]});
            end
            e6 = exp_rd6(int'(a6));
            chk("cmp6_outA", {12'h0, oa6}, {12'h0, e6});
            chk("cmp6_zeroA", {15'h0, za6}, {15'h0, e6 == 4'h0});
            chk("cmp6_outB", {12'h0, ob6}, {12'h0, exp_rd6(int'(b6))});
            chk("cmp6_wrap", {10'h0, w6}, {10'h0, RST ? 6'h00 : m6_w});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic op(input logic [1:0] fs, input logic [3:0] rs,
                      input logic [7:0] din, input logic fc);
        FunSel = fs; RegSel = rs; I = din; FlagClr = fc;
        @(posedge CLK); #1;
        RegSel = 4'h0; FlagClr = 1'b0;
    endtask

    task automatic op6(input logic [1:0] fs, input logic [5:0] rs, input logic [3:0] din);
        f6 = fs; rs6 = rs; i6 = din;
        @(posedge CLK); #1;
        rs6 = 6'h00;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b0; FunSel = CLR; RegSel = 4'h0; I = 8'h00;
        OutASel = 2'd0; OutBSel = 2'd0; FlagClr = 1'b0;
        f6 = CLR; rs6 = 6'h00; i6 = 4'h0; a6 = 3'd0; b6 = 3'd0; fc6 = 1'b0;
        #1 RST = 1'b1;
        #2;
        chk("rst_outA", {8'h0, oa[0]}, 16'h0000);
        chk("rst_zeroA", {15'h0, za[0]}, 16'h0001);
        @(negedge CLK); #1 RST = 1'b0;
        cmp_en = 1;

        // Reset mid-clock with registers holding 0xAA; pending load is discarded.
        op(LD, 4'b1111, 8'hAA, 1'b0);
        chk("pre_rst_outA", {8'h0, oa[0]}, 16'h00AA);
        #2 RST = 1'b1;
        #1;
        chk("midrst_outA", {8'h0, oa[0]}, 16'h0000);
        chk("midrst_outB", {8'h0, ob[1]}, 16'h0000);
        chk("midrst_zeroA", {15'h0, za[2]}, 16'h0001);
        chk("midrst_wrap", {12'h0, wr[0]}, 16'h0000);
        FunSel = LD; RegSel = 4'b1111; I = 8'h55;
        @(posedge CLK); #1;
        chk("inrst_outA_byp", {8'h0, oa[2]}, 16'h0000);
        @(negedge CLK); #1;
        RST = 1'b0; RegSel = 4'h0;
        #1 chk("postrst_outA", {8'h0, oa[0]}, 16'h0000);

        // Multi-load and read sweep.
        op(LD, 4'b1011, 8'hAA, 1'b0);
        for (int a = 0; a < 4; a++) begin
            OutASel = a[1:0]; OutBSel = 2'(3 - a);
            #1;
            chk("sweep_outA", {8'h0, oa[0]}, (a == 2) ? 16'h0000 : 16'h00AA);
            chk("sweep_outB", {8'h0, ob[0]}, (a == 1) ? 16'h0000 : 16'h00AA);
        end

        // Wrap vs saturate on R2.
        OutASel = 2'd2;
        op(LD, 4'b0100, 8'hFF, 1'b0);
        op(INC, 4'b0100, 8'h00, 1'b0);
        chk("wrap_inc_R2", {8'h0, oa[0]}, 16'h0000);
        chk("wrap_inc_flag", {12'h0, wr[0]}, 16'h0004);
        chk("sat_inc_R2", {8'h0, oa[1]}, 16'h00FF);
        op(DEC, 4'b0100, 8'h00, 1'b0);
        chk("wrap_dec_R2", {8'h0, oa[0]}, 16'h00FF);
        chk("wrap_dec_flag", {12'h0, wr[0]}, 16'h0004);
        chk("sat_dec_R2", {8'h0, oa[1]}, 16'h00FE);
        op(CLR, 4'b0000, 8'h00, 1'b1);
        chk("flagclr_wrap", {12'h0, wr[0]}, 16'h0000);
        chk("flagclr_sat", {12'h0, wr[1]}, 16'h0000);

        // Saturate on R1.
        OutASel = 2'd1;
        op(CLR, 4'b0010, 8'h00, 1'b0);
        op(DEC, 4'b0010, 8'h00, 1'b0);
        op(DEC, 4'b0010, 8'h00, 1'b0);
        chk("sat_dec2_R1", {8'h0, oa[1]}, 16'h0000);
        chk("sat_dec2_flag", {12'h0, wr[1]}, 16'h0002);
        chk("wrap_dec2_R1", {8'h0, oa[0]}, 16'h00FE);
        op(LD, 4'b0010, 8'hFE, 1'b0);
        for (int n = 0; n < 3; n++) op(INC, 4'b0010, 8'h00, 1'b0);
        chk("sat_inc3_R1", {8'h0, oa[1]}, 16'h00FF);
        chk("wrap_inc3_R1", {8'h0, oa[0]}, 16'h0001);
        op(CLR, 4'b0000, 8'h00, 1'b1);
        chk("sat_clr_flag", {12'h0, wr[1]}, 16'h0000);
        op(INC, 4'b0010, 8'h00, 1'b1);
        chk("set_wins_flag", {12'h0, wr[1]}, 16'h0002);
        chk("set_wins_R1", {8'h0, oa[1]}, 16'h00FF);
        chk("no_evt_clr_flag", {12'h0, wr[0]}, 16'h0000);

        // Bypass on R0.
        OutASel = 2'd0;
        op(LD, 4'b0001, 8'h11, 1'b0);
        FunSel = LD; RegSel = 4'b0001; I = 8'h5C;
        #1;
        chk("byp_load_pre", {8'h0, oa[2]}, 16'h005C);
        chk("nobyp_load_pre", {8'h0, oa[0]}, 16'h0011);
        @(posedge CLK); #1;
        chk("byp_load_post", {8'h0, oa[2]}, 16'h005C);
        RegSel = 4'h0;
        op(LD, 4'b0001, 8'h11, 1'b0);
        FunSel = INC; RegSel = 4'b0001; I = 8'h5C;
        #1;
        chk("byp_inc_pre", {8'h0, oa[2]}, 16'h0011);
        @(posedge CLK); #1;
        RegSel = 4'h0;
        #1 chk("byp_inc_post", {8'h0, oa[2]}, 16'h0012);
        FunSel = LD; RegSel = 4'b0001; I = 8'h00;
        #1;
        chk("byp_zeroA", {15'h0, za[2]}, 16'h0001);
        chk("nobyp_zeroA", {15'h0, za[0]}, 16'h0000);
        @(negedge CLK); #1;
        RegSel = 4'h0;

        // DEPTH=6, WIDTH=4 instance.
        a6 = 3'd7; b6 = 3'd6;
        #1;
        chk("p6_oob_outA", {12'h0, oa6}, 16'h0000);
        chk("p6_oob_zeroA", {15'h0, za6}, 16'h0001);
        op6(LD, 6'b100000, 4'hF);
        a6 = 3'd5;
        #1 chk("p6_load_R5", {12'h0, oa6}, 16'h000F);
        op6(INC, 6'b100000, 4'h0);
        chk("p6_inc_R5", {12'h0, oa6}, 16'h0000);
        chk("p6_wrap", {10'h0, w6}, 16'h0020);
        op6(LD, 6'b010000, 4'h3);
        op6(DEC, 6'b110000, 4'h0);
        b6 = 3'd4;
        #1;
        chk("p6_dec_R4", {12'h0, ob6}, 16'h0002);
        chk("p6_dec_R5", {12'h0, oa6}, 16'h000F);
        chk("p6_wrap2", {10'h0, w6}, 16'h0020);

        @(negedge CLK); #1;
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
